// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith ops, plus an iterative multiply/divide engine.
// Multiply/divide is built only when ALU_MULDIV_EN is defined; otherwise codes 8-D pass A.
module alu_seq #(
   parameter int WIDTH = 32
) (
   input  logic             iCLK,
   input  logic             iRST,
   input  logic             iValid,
   input  logic [3:0]       iControl,
   input  logic [WIDTH-1:0] iA,
   input  logic [WIDTH-1:0] iB,
   output logic             oReady,
   output logic             oValid,
   output logic [WIDTH-1:0] oResult,
   output logic             oBusy
);

`ifdef ALU_MULDIV_EN
   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
`else
   typedef enum logic {S_IDLE, S_DONE} state_t;
`endif

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] result_reg;
   logic [WIDTH-1:0] simple_result;
   logic             accept;

   assign accept = (state_reg == S_IDLE) && iValid;

   always_comb begin
      simple_result = iA;
      case (iControl)
         4'h0: simple_result = iA & iB;
         4'h1: simple_result = iA | iB;
         4'h2: simple_result = iA + iB;
         4'h3: simple_result = iA - iB;
         4'h4: begin
            simple_result    = '0;
            simple_result[0] = $signed(iA) < $signed(iB);
         end
         4'h5: simple_result = iB;
         4'h6: begin
            simple_result    = '0;
            simple_result[0] = iA < iB;
         end
         4'h7: simple_result = iA ^ iB;
         default: simple_result = iA;
      endcase
   end

`ifdef ALU_MULDIV_EN
   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   logic [CW-1:0]    count_reg;
   logic [3:0]       op_reg;
   logic             neg_reg;
   logic [WIDTH-1:0] hi_reg, lo_reg, b_reg;
   logic             last_iter;

   logic             is_mul, is_div, is_quo, op_signed, a_neg, b_neg;
   logic             div_zero, div_ovf, div_special, neg_next;
   logic [WIDTH-1:0] a_mag, b_mag, special_result;

   // Accept-time decode: magnitudes, result sign and the divide corner cases
   always_comb begin
      is_mul      = (iControl == 4'h8) || (iControl == 4'h9);
      is_div      = (iControl >= 4'hA) && (iControl <= 4'hD);
      is_quo      = (iControl == 4'hA) || (iControl == 4'hB);
      op_signed   = is_mul || (iControl == 4'hA) || (iControl == 4'hC);
      a_neg       = op_signed && iA[WIDTH-1];
      b_neg       = op_signed && iB[WIDTH-1];
      a_mag       = a_neg ? -iA : iA;
      b_mag       = b_neg ? -iB : iB;
      neg_next    = (iControl == 4'hC) ? a_neg : (a_neg ^ b_neg);
      div_zero    = (iB == '0);
      div_ovf     = ((iControl == 4'hA) || (iControl == 4'hC)) && (iA == MOST_NEG) && (iB == '1);
      div_special = is_div && (div_zero || div_ovf);
      special_result = '0;
      if (div_zero)
         special_result = is_quo ? '1 : iA;
      else if (div_ovf)
         special_result = is_quo ? iA : '0;
   end

   assign last_iter = (count_reg == CW'(WIDTH - 1));

   // Shift-add multiply: hi_reg accumulates, lo_reg holds the multiplier shifting out
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH-1:0]   mul_hi_next, mul_lo_next, mul_result;
   logic [2*WIDTH-1:0] mul_prod, mul_fix;

   always_comb begin
      mul_sum     = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_reg} : '0);
      mul_hi_next = mul_sum[WIDTH:1];
      mul_lo_next = {mul_sum[0], lo_reg[WIDTH-1:1]};
      mul_prod    = {mul_hi_next, mul_lo_next};
      mul_fix     = neg_reg ? -mul_prod : mul_prod;
      mul_result  = (op_reg == 4'h9) ? mul_fix[2*WIDTH-1:WIDTH] : mul_fix[WIDTH-1:0];
   end

   // Restoring divide: hi_reg is the partial remainder, lo_reg shifts dividend out / quotient in
   logic [WIDTH:0]   div_shift;
   logic             div_ge;
   logic [WIDTH-1:0] div_sub, div_rem_next, div_quo_next, div_result;

   always_comb begin
      div_shift    = {hi_reg, lo_reg[WIDTH-1]};
      div_ge       = div_shift >= {1'b0, b_reg};
      div_sub      = div_shift[WIDTH-1:0] - b_reg;
      div_rem_next = div_ge ? div_sub : div_shift[WIDTH-1:0];
      div_quo_next = {lo_reg[WIDTH-2:0], div_ge};
      if ((op_reg == 4'hA) || (op_reg == 4'hB))
         div_result = neg_reg ? -div_quo_next : div_quo_next;
      else
         div_result = neg_reg ? -div_rem_next : div_rem_next;
   end
`endif

   always_ff @(posedge iCLK) begin
      if (iRST)
         state_reg <= S_IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: begin
            if (iValid) begin
`ifdef ALU_MULDIV_EN
               if (is_mul)
                  state_next = S_MUL;
               else if (is_div && !div_special)
                  state_next = S_DIV;
               else
                  state_next = S_DONE;
`else
               state_next = S_DONE;
`endif
            end
         end
`ifdef ALU_MULDIV_EN
         S_MUL: if (last_iter) state_next = S_DONE;
         S_DIV: if (last_iter) state_next = S_DONE;
`endif
         S_DONE: state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         result_reg <= '0;
`ifdef ALU_MULDIV_EN
         count_reg  <= '0;
         op_reg     <= '0;
         neg_reg    <= 1'b0;
         hi_reg     <= '0;
         lo_reg     <= '0;
         b_reg      <= '0;
`endif
      end else if (accept) begin
`ifdef ALU_MULDIV_EN
         if (is_mul || (is_div && !div_special)) begin
            op_reg    <= iControl;
            neg_reg   <= neg_next;
            hi_reg    <= '0;
            lo_reg    <= a_mag;
            b_reg     <= b_mag;
            count_reg <= '0;
         end else if (is_div) begin
            result_reg <= special_result;
         end else begin
            result_reg <= simple_result;
         end
`else
         result_reg <= simple_result;
`endif
      end
`ifdef ALU_MULDIV_EN
      else if (state_reg == S_MUL) begin
         hi_reg    <= mul_hi_next;
         lo_reg    <= mul_lo_next;
         count_reg <= last_iter ? '0 : count_reg + CW'(1);
         if (last_iter) result_reg <= mul_result;
      end else if (state_reg == S_DIV) begin
         hi_reg    <= div_rem_next;
         lo_reg    <= div_quo_next;
         count_reg <= last_iter ? '0 : count_reg + CW'(1);
         if (last_iter) result_reg <= div_result;
      end
`endif
   end

   assign oReady  = (state_reg == S_IDLE);
   assign oValid  = (state_reg == S_DONE);
   assign oResult = result_reg;
`ifdef ALU_MULDIV_EN
   assign oBusy   = (state_reg == S_MUL) || (state_reg == S_DIV);
`else
   assign oBusy   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq (WIDTH=32); expectations follow ALU_MULDIV_EN when defined.
module tb_alu_seq;
   logic        iCLK = 1'b0;
   logic        iRST;
   logic        iValid;
   logic [3:0]  iControl;
   logic [31:0] iA, iB;
   logic        oReady, oValid, oBusy;
   logic [31:0] oResult;

   int tests = 0;
   int fails = 0;

   alu_seq #(.WIDTH(32)) dut (
      .iCLK(iCLK), .iRST(iRST), .iValid(iValid), .iControl(iControl),
      .iA(iA), .iB(iB), .oReady(oReady), .oValid(oValid),
      .oResult(oResult), .oBusy(oBusy)
   );

   always #5 iCLK = ~iCLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required finish before 2000000");
      $fatal(1, "watchdog");
   end

`ifdef ALU_MULDIV_EN
   localparam int MD_LAT = 33;
   localparam int MD_BUSY = 32;
`else
   localparam int MD_LAT = 1;
   localparam int MD_BUSY = 0;
`endif

   // Call at a negedge with oReady high; returns at the negedge of the cycle after oValid.
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output logic rdy_valid,
                         output logic rdy_next, output logic [31:0] res_next, output int busy);
      iControl = op; iA = a; iB = b; iValid = 1'b1;
      lat = 0; busy = 0; rdy_valid = 1'bx; res = 'x;
      while (lat < 100) begin
         @(negedge iCLK);
         iValid = 1'b0;
         iA = ~a; iB = ~b;
         lat++;
         if (oBusy) busy++;
         if (oValid) begin
            res = oResult;
            rdy_valid = oReady;
            break;
         end
      end
      @(negedge iCLK);
      rdy_next = oReady;
      res_next = oResult;
   endtask

   task automatic test_reset();
      iRST = 1'b1; iValid = 1'b0; iControl = '0; iA = '0; iB = '0;
      repeat (2) @(negedge iCLK);
      iRST = 1'b0;
      tests++; if (oReady !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", oReady); end
      tests++; if (oValid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", oValid); end
      tests++; if (oResult !== 32'h0) begin fails++; $display("FAIL reset_result: got %h want 0", oResult); end
      tests++; if (oBusy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", oBusy); end
      $display("[TB] reset: ready=%b valid=%b result=%h busy=%b", oReady, oValid, oResult, oBusy);
   endtask

   task automatic test_simple();
      logic [3:0]  ops  [9] = '{4'h2, 4'h3, 4'h4, 4'h6, 4'h5, 4'h0, 4'h1, 4'h7, 4'hE};
      logic [31:0] as   [9] = '{32'h7FFFFFFF, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5,
                               32'h0000F0F0, 32'h0000F0F0, 32'h0000F0F0, 32'h00001234};
      logic [31:0] bs   [9] = '{32'h1, 32'h1, 32'h1, 32'h1, 32'd9,
                               32'h0000FF00, 32'h0000FF00, 32'h0000FF00, 32'h0000BEEF};
      logic [31:0] exps [9] = '{32'h80000000, 32'hFFFFFFFF, 32'h1, 32'h0, 32'd9,
                               32'h0000F000, 32'h0000FFF0, 32'h00000FF0, 32'h00001234};
      logic [31:0] res, res_n;
      logic        rv, rn;
      int          lat, busy;
      for (int i = 0; i < 9; i++) begin
         run_op(ops[i], as[i], bs[i], res, lat, rv, rn, res_n, busy);
         $display("[TB] op=%h a=%h b=%h -> %h lat=%0d", ops[i], as[i], bs[i], res, lat);
         tests++; if (res !== exps[i]) begin fails++; $display("FAIL simple_res op=%h: got %h want %h", ops[i], res, exps[i]); end
         tests++; if (lat != 1) begin fails++; $display("FAIL simple_lat op=%h: got %0d want 1", ops[i], lat); end
         tests++; if (rv !== 1'b0 || rn !== 1'b1) begin fails++; $display("FAIL simple_ready op=%h: got %b%b want 01", ops[i], rv, rn); end
      end
   endtask

   task automatic test_muldiv();
      logic [3:0]  ops  [7] = '{4'h8, 4'h9, 4'h9, 4'hA, 4'hC, 4'hB, 4'hD};
      logic [31:0] as   [7] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFF9,
                               32'hFFFFFFF9, 32'hFFFFFFFE, 32'd100};
      logic [31:0] bs   [7] = '{32'd7, 32'd7, 32'h80000000, 32'd2, 32'd2, 32'd2, 32'd7};
`ifdef ALU_MULDIV_EN
      logic [31:0] exps [7] = '{32'hFFFFFFEB, 32'hFFFFFFFF, 32'h40000000, 32'hFFFFFFFD,
                               32'hFFFFFFFF, 32'h7FFFFFFF, 32'd2};
`else
      logic [31:0] exps [7] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFF9,
                               32'hFFFFFFF9, 32'hFFFFFFFE, 32'd100};
`endif
      logic [31:0] res, res_n;
      logic        rv, rn;
      int          lat, busy;
      for (int i = 0; i < 7; i++) begin
         run_op(ops[i], as[i], bs[i], res, lat, rv, rn, res_n, busy);
         $display("[TB] op=%h a=%h b=%h -> %h lat=%0d busy=%0d", ops[i], as[i], bs[i], res, lat, busy);
         tests++; if (res !== exps[i]) begin fails++; $display("FAIL md_res op=%h: got %h want %h", ops[i], res, exps[i]); end
         tests++; if (lat != MD_LAT) begin fails++; $display("FAIL md_lat op=%h: got %0d want %0d", ops[i], lat, MD_LAT); end
         tests++; if (busy != MD_BUSY) begin fails++; $display("FAIL md_busy op=%h: got %0d want %0d", ops[i], busy, MD_BUSY); end
         tests++; if (rn !== 1'b1) begin fails++; $display("FAIL md_ready op=%h: got %b want 1", ops[i], rn); end
      end
   endtask

   task automatic test_special();
      logic [3:0]  ops  [4] = '{4'hA, 4'hD, 4'hA, 4'hC};
      logic [31:0] as   [4] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
      logic [31:0] bs   [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
`ifdef ALU_MULDIV_EN
      logic [31:0] exps [4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0};
`else
      logic [31:0] exps [4] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
`endif
      logic [31:0] res, res_n;
      logic        rv, rn;
      int          lat, busy;
      for (int i = 0; i < 4; i++) begin
         run_op(ops[i], as[i], bs[i], res, lat, rv, rn, res_n, busy);
         $display("[TB] special op=%h a=%h b=%h -> %h lat=%0d", ops[i], as[i], bs[i], res, lat);
         tests++; if (res !== exps[i]) begin fails++; $display("FAIL special_res op=%h: got %h want %h", ops[i], res, exps[i]); end
         tests++; if (lat != 1) begin fails++; $display("FAIL special_lat op=%h: got %0d want 1", ops[i], lat); end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] res, res_n;
      logic        rv, rn;
      int          lat, busy;
      run_op(4'h2, 32'd10, 32'd20, res, lat, rv, rn, res_n, busy);
      $display("[TB] b2b first -> %h held=%h", res, res_n);
      tests++; if (res_n !== 32'd30) begin fails++; $display("FAIL b2b_hold: got %h want %h", res_n, 32'd30); end
      run_op(4'h3, 32'd10, 32'd20, res, lat, rv, rn, res_n, busy);
      $display("[TB] b2b second -> %h lat=%0d", res, lat);
      tests++; if (res !== 32'hFFFFFFF6) begin fails++; $display("FAIL b2b_res: got %h want FFFFFFF6", res); end
      tests++; if (lat != 1) begin fails++; $display("FAIL b2b_lat: got %0d want 1", lat); end
   endtask

   task automatic test_handshake();
      int          pulses = 0;
      int          first = 0;
      logic [31:0] res = '0;
      iControl = 4'h8; iA = 32'd3; iB = 32'd4; iValid = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge iCLK);
         iA = 32'(c + 10); iB = 32'(c + 20);
         if (oValid) begin
            pulses++;
            if (first == 0) begin first = c; res = oResult; end
            iValid = 1'b0;
         end
      end
      iValid = 1'b0;
`ifdef ALU_MULDIV_EN
      $display("[TB] handshake MUL 3x4 held valid -> %h at %0d pulses=%0d", res, first, pulses);
      tests++; if (res !== 32'd12) begin fails++; $display("FAIL hs_res: got %h want %h", res, 32'd12); end
`else
      $display("[TB] handshake MUL 3x4 (no muldiv) -> %h at %0d pulses=%0d", res, first, pulses);
      tests++; if (res !== 32'd3) begin fails++; $display("FAIL hs_res: got %h want %h", res, 32'd3); end
`endif
      tests++; if (first != MD_LAT) begin fails++; $display("FAIL hs_lat: got %0d want %0d", first, MD_LAT); end
      tests++; if (pulses != 1) begin fails++; $display("FAIL hs_pulses: got %0d want 1", pulses); end
   endtask

   task automatic test_reset_mid();
      int pulses = 0;
      iControl = 4'hA; iA = 32'd100; iB = 32'd7; iValid = 1'b1;
      @(negedge iCLK);
      iValid = 1'b0;
      repeat (9) @(negedge iCLK);
      iRST = 1'b1;
      @(negedge iCLK);
      iRST = 1'b0;
      $display("[TB] reset mid-op: ready=%b valid=%b busy=%b result=%h", oReady, oValid, oBusy, oResult);
      tests++; if (oReady !== 1'b1) begin fails++; $display("FAIL rmid_ready: got %b want 1", oReady); end
      tests++; if (oValid !== 1'b0) begin fails++; $display("FAIL rmid_valid: got %b want 0", oValid); end
      tests++; if (oBusy !== 1'b0) begin fails++; $display("FAIL rmid_busy: got %b want 0", oBusy); end
      tests++; if (oResult !== 32'h0) begin fails++; $display("FAIL rmid_result: got %h want 0", oResult); end
      for (int c = 0; c < 40; c++) begin
         @(negedge iCLK);
         if (oValid) pulses++;
      end
      tests++; if (pulses != 0) begin fails++; $display("FAIL rmid_stray_valid: got %0d want 0", pulses); end
   endtask

   initial begin
      iRST = 1'b1; iValid = 1'b0; iControl = '0; iA = '0; iB = '0;
      @(negedge iCLK);
      test_reset();
      test_simple();
      test_muldiv();
      test_special();
      test_back_to_back();
      test_handshake();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
